// File: rtl/mem_pkg.sv
// Shared encodings for the MOV/MOC memory: access sizes, direction and FSM states.
package mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mem_moc_unit_if.sv
// Request/complete handshake bundle between the CPU's MAR/MDR and the memory.
interface mem_moc_unit_if;
  logic        mov;
  logic        rw;
  logic [1:0]  size;
  logic        unsign;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        err;

  modport master (output mov, rw, size, unsign, address, data_in,
                  input  data_out, moc, err);
  modport slave  (input  mov, rw, size, unsign, address, data_in,
                  output data_out, moc, err);
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: read extraction/extension and write byte enables.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsign_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic        fmt_err_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte     = 8'h00;
    rhalf     = 16'h0000;
    rdata_o   = '0;
    be_o      = 4'b0000;
    wword_o   = '0;
    fmt_err_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        // Offset 0 lives in the most significant lane.
        case (offset_i)
          2'd0:    rbyte = rword_i[31:24];
          2'd1:    rbyte = rword_i[23:16];
          2'd2:    rbyte = rword_i[15:8];
          default: rbyte = rword_i[7:0];
        endcase
        rdata_o = unsign_i ? {24'h000000, rbyte} : {{24{rbyte[7]}}, rbyte};
        be_o    = 4'b1000 >> offset_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        fmt_err_o = offset_i[0];
        rhalf     = offset_i[1] ? rword_i[15:0] : rword_i[31:16];
        rdata_o   = unsign_i ? {16'h0000, rhalf} : {{16{rhalf[15]}}, rhalf};
        be_o      = offset_i[1] ? 4'b0011 : 4'b1100;
        wword_o   = {2{wdata_i[15:0]}};
      end
      SZ_WORD: begin
        fmt_err_o = (offset_i != 2'b00);
        rdata_o   = rword_i;
        be_o      = 4'b1111;
        wword_o   = wdata_i;
      end
      default: fmt_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_moc_unit.sv
// Multi-cycle byte-addressed memory: accepts a MOV request, waits LATENCY cycles,
// performs the access and holds MOC until the request is withdrawn.
module mem_moc_unit
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 3
)(
  input  logic         clk,
  input  logic         reset,
  mem_moc_unit_if.slave bus
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [31:0] mem [DEPTH_BYTES/4];

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q;
  logic               rw_q;
  size_e              size_q;
  logic               unsign_q;
  logic [31:0]        wdata_q;
  logic [DATA_W-1:0]  dout_q;
  logic               moc_q;
  logic               err_q;

  logic [31:0] rword;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic [31:0] wword;
  logic        fmt_err;
  logic        acc_err;
  logic        fire;
  logic        mem_we;
  logic [31:0] dout_d;

  assign rword = mem[addr_q[AW-1:2]];

  mem_lane_align u_align (
    .offset_i  (addr_q[1:0]),
    .size_i    (size_q),
    .unsign_i  (unsign_q),
    .rword_i   (rword),
    .wdata_i   (wdata_q),
    .rdata_o   (rdata),
    .be_o      (be),
    .wword_o   (wword),
    .fmt_err_o (fmt_err)
  );

  assign acc_err = fmt_err || (addr_q >= 32'(DEPTH_BYTES));
  assign fire    = (state_q == ST_BUSY) && (cnt_q == '0);
  // Reset in the commit cycle abandons the write.
  assign mem_we  = fire && !reset && !acc_err && (rw_q == RW_WRITE);
  assign dout_d  = (!acc_err && rw_q == RW_READ) ? rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.mov) begin
            addr_q   <= bus.address;
            rw_q     <= bus.rw;
            size_q   <= size_e'(bus.size);
            unsign_q <= bus.unsign;
            wdata_q  <= bus.data_in;
            cnt_q    <= CNT_W'(LATENCY - 1);
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            moc_q   <= 1'b1;
            err_q   <= acc_err;
            dout_q  <= dout_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          // Staying here while mov is held prevents a re-trigger.
          if (!bus.mov) begin
            state_q <= ST_IDLE;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr_q[AW-1:2]][b*8 +: 8] <= wword[b*8 +: 8];
      end
    end
  end

  assign bus.data_out = dout_q;
  assign bus.moc      = moc_q;
  assign bus.err      = err_q;

endmodule
